// File: rtl/fc_pkg.sv
// Shared types and default widths for the PCIe transmit flow-control gate.
package fc_pkg;

  localparam int unsigned FC_HDR_W       = 8;
  localparam int unsigned FC_DATA_W      = 12;
  localparam int unsigned FC_NUM_CLASSES = 3;

  typedef enum logic [1:0] {
    FC_P   = 2'd0,
    FC_NP  = 2'd1,
    FC_CPL = 2'd2
  } fc_class_e;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    EVAL  = 2'd1,
    GRANT = 2'd2,
    WAIT  = 2'd3
  } fc_state_e;

endpackage

// File: rtl/fc_credit_gate_if.sv
// Scheduler/DLL-facing signal bundle of fc_credit_gate.
interface fc_credit_gate_if
  import fc_pkg::*;
#(
  parameter int unsigned HDR_W  = FC_HDR_W,
  parameter int unsigned DATA_W = FC_DATA_W
) ();

  logic              fc_init_done;
  logic              fc_upd_valid;
  logic [1:0]        fc_upd_class;
  logic [HDR_W-1:0]  fc_upd_hdr;
  logic [DATA_W-1:0] fc_upd_data;
  logic              tlp_valid;
  logic [1:0]        tlp_class;
  logic [DATA_W-1:0] tlp_data_cr;
  logic              tlp_grant;
  logic              tlp_blocked;
  logic [HDR_W-1:0]  cc_hdr;

  modport master (
    output fc_init_done, fc_upd_valid, fc_upd_class, fc_upd_hdr, fc_upd_data,
    output tlp_valid, tlp_class, tlp_data_cr,
    input  tlp_grant, tlp_blocked, cc_hdr
  );

  modport slave (
    input  fc_init_done, fc_upd_valid, fc_upd_class, fc_upd_hdr, fc_upd_data,
    input  tlp_valid, tlp_class, tlp_data_cr,
    output tlp_grant, tlp_blocked, cc_hdr
  );

endinterface

// File: rtl/fc_credit_check.sv
// Modular credit test for one field: pass when (cl - (cc + req)) mod 2^W <= 2^(W-1).
module fc_credit_check #(
  parameter int unsigned W = 8
) (
  input  logic [W-1:0] cl,
  input  logic [W-1:0] cc,
  input  logic [W-1:0] req,
  output logic         pass_c
);

  localparam logic [W-1:0] HALF = {1'b1, {(W-1){1'b0}}};

  logic [W-1:0] sum;
  logic [W-1:0] diff;

  assign sum    = cc + req;
  assign diff   = cl - sum;
  assign pass_c = (diff <= HALF);

endmodule

// File: rtl/fc_credit_gate.sv
// PCIe transmit flow-control gate tracking CC/CL for the P, NP and Cpl classes.
// Optional FC_INFINITE_CREDIT_EN: limits that are zero when fc_init_done rises become infinite.
module fc_credit_gate
  import fc_pkg::*;
#(
  parameter int unsigned HDR_W  = FC_HDR_W,
  parameter int unsigned DATA_W = FC_DATA_W
) (
  input  logic             clk,
  input  logic             rst,
  fc_credit_gate_if.slave  bus
);

  localparam int unsigned NC = FC_NUM_CLASSES;

  fc_state_e         state_q, state_d;
  logic [HDR_W-1:0]  cc_h_q [NC];
  logic [HDR_W-1:0]  cc_h_d [NC];
  logic [DATA_W-1:0] cc_d_q [NC];
  logic [DATA_W-1:0] cc_d_d [NC];
  logic [HDR_W-1:0]  cl_h_q [NC];
  logic [HDR_W-1:0]  cl_h_d [NC];
  logic [DATA_W-1:0] cl_d_q [NC];
  logic [DATA_W-1:0] cl_d_d [NC];
  logic              upd_hit_q, upd_hit_d;
  logic              grant_q, grant_d;
  logic              blocked_q, blocked_d;
  logic [HDR_W-1:0]  cc_hdr_q, cc_hdr_d;

  logic              cls_ok;
  logic [HDR_W-1:0]  sel_cc_h, sel_cl_h;
  logic [DATA_W-1:0] sel_cc_d, sel_cl_d;
  logic              sel_inf_h, sel_inf_d;
  logic              hdr_pass_c, data_pass_c, pass_c;
  logic [NC-1:0]     inf_h, inf_d;

`ifdef FC_INFINITE_CREDIT_EN
  logic          init_q, init_d;
  logic [NC-1:0] inf_h_q, inf_h_d, inf_d_q, inf_d_d;

  // Zero limits seen on the rising edge of fc_init_done stay infinite until reset.
  always_comb begin
    init_d  = bus.fc_init_done;
    inf_h_d = inf_h_q;
    inf_d_d = inf_d_q;
    if (bus.fc_init_done && !init_q) begin
      for (int i = 0; i < int'(NC); i++) begin
        if (cl_h_q[i] == '0) inf_h_d[i] = 1'b1;
        if (cl_d_q[i] == '0) inf_d_d[i] = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      init_q  <= 1'b0;
      inf_h_q <= '0;
      inf_d_q <= '0;
    end else begin
      init_q  <= init_d;
      inf_h_q <= inf_h_d;
      inf_d_q <= inf_d_d;
    end
  end

  assign inf_h = inf_h_q;
  assign inf_d = inf_d_q;
`else
  assign inf_h = '0;
  assign inf_d = '0;
`endif

  // Limit overwrite from UpdateFC and consumed-credit advance on grant.
  always_comb begin
    cc_h_d = cc_h_q;
    cc_d_d = cc_d_q;
    cl_h_d = cl_h_q;
    cl_d_d = cl_d_q;
    for (int i = 0; i < int'(NC); i++) begin
      if (bus.fc_upd_valid && (bus.fc_upd_class == 2'(i))) begin
        if (!inf_h[i]) cl_h_d[i] = bus.fc_upd_hdr;
        if (!inf_d[i]) cl_d_d[i] = bus.fc_upd_data;
      end
      if ((state_q == GRANT) && (bus.tlp_class == 2'(i))) begin
        cc_h_d[i] = cc_h_q[i] + HDR_W'(1);
        cc_d_d[i] = cc_d_q[i] + bus.tlp_data_cr;
      end
    end
  end

  // Counters and limits of the requested class; class 3 never passes.
  always_comb begin
    cls_ok    = 1'b0;
    sel_cc_h  = '0;
    sel_cl_h  = '0;
    sel_cc_d  = '0;
    sel_cl_d  = '0;
    sel_inf_h = 1'b0;
    sel_inf_d = 1'b0;
    for (int i = 0; i < int'(NC); i++) begin
      if (bus.tlp_class == 2'(i)) begin
        cls_ok    = 1'b1;
        sel_cc_h  = cc_h_q[i];
        sel_cl_h  = cl_h_q[i];
        sel_cc_d  = cc_d_q[i];
        sel_cl_d  = cl_d_q[i];
        sel_inf_h = inf_h[i];
        sel_inf_d = inf_d[i];
      end
    end
  end

  fc_credit_check #(.W(HDR_W)) u_hdr_chk (
    .cl     (sel_cl_h),
    .cc     (sel_cc_h),
    .req    (HDR_W'(1)),
    .pass_c (hdr_pass_c)
  );

  fc_credit_check #(.W(DATA_W)) u_data_chk (
    .cl     (sel_cl_d),
    .cc     (sel_cc_d),
    .req    (bus.tlp_data_cr),
    .pass_c (data_pass_c)
  );

  assign pass_c = cls_ok && (hdr_pass_c || sel_inf_h) && (data_pass_c || sel_inf_d);

  // An update colliding with EVAL is remembered so the resulting WAIT re-evaluates.
  always_comb begin
    upd_hit_d = bus.fc_upd_valid && (bus.fc_upd_class == bus.tlp_class);
    state_d   = state_q;
    case (state_q)
      IDLE:    if (bus.tlp_valid && bus.fc_init_done) state_d = EVAL;
      EVAL:    if (!bus.tlp_valid)                    state_d = IDLE;
               else if (pass_c)                       state_d = GRANT;
               else                                   state_d = WAIT;
      GRANT:                                          state_d = IDLE;
      WAIT:    if (!bus.tlp_valid)                    state_d = IDLE;
               else if (upd_hit_d || upd_hit_q)       state_d = EVAL;
      default:                                        state_d = IDLE;
    endcase
  end

  // Registered outputs follow the next state so they align with GRANT/WAIT.
  always_comb begin
    grant_d   = (state_d == GRANT);
    blocked_d = (state_d == WAIT);
    cc_hdr_d  = '0;
    for (int i = 0; i < int'(NC); i++) begin
      if (bus.tlp_class == 2'(i)) cc_hdr_d = cc_h_d[i];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      cc_h_q    <= '{default: '0};
      cc_d_q    <= '{default: '0};
      cl_h_q    <= '{default: '0};
      cl_d_q    <= '{default: '0};
      upd_hit_q <= 1'b0;
      grant_q   <= 1'b0;
      blocked_q <= 1'b0;
      cc_hdr_q  <= '0;
    end else begin
      state_q   <= state_d;
      cc_h_q    <= cc_h_d;
      cc_d_q    <= cc_d_d;
      cl_h_q    <= cl_h_d;
      cl_d_q    <= cl_d_d;
      upd_hit_q <= upd_hit_d;
      grant_q   <= grant_d;
      blocked_q <= blocked_d;
      cc_hdr_q  <= cc_hdr_d;
    end
  end

  assign bus.tlp_grant   = grant_q;
  assign bus.tlp_blocked = blocked_q;
  assign bus.cc_hdr      = cc_hdr_q;

endmodule

// File: tb/tb_fc_credit_gate.sv
// Self-checking bench for fc_credit_gate: directed scenarios plus a $urandom phase vs a credit-ledger model.
module tb_fc_credit_gate;
  import fc_pkg::*;

  localparam int unsigned HW = FC_HDR_W;
  localparam int unsigned DW = FC_DATA_W;
  localparam int HM = 1 << HW;
  localparam int DM = 1 << DW;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  fc_credit_gate_if #(.HDR_W(HW), .DATA_W(DW)) bus ();

  fc_credit_gate #(.HDR_W(HW), .DATA_W(DW)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  // Credit ledger: plain integers per class, limits and consumed counts.
  int m_cc_h [3];
  int m_cc_d [3];
  int m_cl_h [3];
  int m_cl_d [3];
  bit m_inf_h [3];
  bit m_inf_d [3];
  int n_cmp = 0;
  int n_err = 0;

  function automatic int wrap(input int v, input int m);
    return ((v % m) + m) % m;
  endfunction

  function automatic bit fits(input int cl, input int cc, input int req, input int m);
    return wrap(cl - (cc + req), m) <= (m / 2);
  endfunction

  function automatic bit model_pass(input int c, input int dcr);
    return (m_inf_h[c] || fits(m_cl_h[c], m_cc_h[c], 1, HM)) &&
           (m_inf_d[c] || fits(m_cl_d[c], m_cc_d[c], dcr, DM));
  endfunction

  task automatic model_consume(input int c, input int dcr);
    m_cc_h[c] = wrap(m_cc_h[c] + 1, HM);
    m_cc_d[c] = wrap(m_cc_d[c] + dcr, DM);
  endtask

  task automatic model_limit(input int c, input int h, input int d);
    if (!m_inf_h[c]) m_cl_h[c] = wrap(h, HM);
    if (!m_inf_d[c]) m_cl_d[c] = wrap(d, DM);
  endtask

  task automatic check(input string tag, input int got, input int want);
    n_cmp++;
    if (got != want) begin
      n_err++;
      $display("FAIL %s: got %0d, want %0d (t=%0t)", tag, got, want, $time);
    end
  endtask

  task automatic upd(input int c, input int h, input int d);
    @(negedge clk);
    bus.fc_upd_valid = 1'b1;
    bus.fc_upd_class = 2'(c);
    bus.fc_upd_hdr   = HW'(wrap(h, HM));
    bus.fc_upd_data  = DW'(wrap(d, DM));
    @(negedge clk);
    bus.fc_upd_valid = 1'b0;
    model_limit(c, h, d);
  endtask

  // Raise a request; returns at the negedge where the gate is evaluating.
  task automatic req_start(input int c, input int dcr);
    @(negedge clk);
    bus.tlp_valid   = 1'b1;
    bus.tlp_class   = 2'(c);
    bus.tlp_data_cr = DW'(dcr);
    @(negedge clk);
  endtask

  task automatic outcome(input string tag, input int c, input int dcr, output bit want);
    want = model_pass(c, dcr);
    @(negedge clk);
    check({tag, ".grant"}, int'(bus.tlp_grant), int'(want));
    check({tag, ".blocked"}, int'(bus.tlp_blocked), int'(!want));
    if (want) begin
      bus.tlp_valid = 1'b0;
      model_consume(c, dcr);
      @(negedge clk);
      check({tag, ".cc_hdr"}, int'(bus.cc_hdr), m_cc_h[c]);
    end
  endtask

  task automatic abort_req(input string tag, input int c);
    @(negedge clk);
    bus.tlp_valid = 1'b0;
    @(negedge clk);
    check({tag, ".abort_blocked"}, int'(bus.tlp_blocked), 0);
    check({tag, ".abort_cc_hdr"}, int'(bus.cc_hdr), m_cc_h[c]);
  endtask

  task automatic wait_grant(input string tag, input int c, input int dcr, input int budget);
    bit seen = 1'b0;
    for (int i = 0; i < budget && !seen; i++) begin
      @(negedge clk);
      if (bus.tlp_grant) seen = 1'b1;
    end
    check({tag, ".grant_in_time"}, int'(seen), 1);
    bus.tlp_valid = 1'b0;
    if (seen) model_consume(c, dcr);
    @(negedge clk);
    check({tag, ".cc_hdr"}, int'(bus.cc_hdr), m_cc_h[c]);
  endtask

  // After a same-class update to a waiting request: expect grant or continued wait.
  task automatic after_upd(input string tag, input int c, input int dcr);
    bit seen = 1'b0;
    if (model_pass(c, dcr)) begin
      wait_grant(tag, c, dcr, 2);
    end else begin
      for (int i = 0; i < 2; i++) begin
        @(negedge clk);
        if (bus.tlp_grant) seen = 1'b1;
      end
      check({tag, ".no_grant"}, int'(seen), 0);
      check({tag, ".still_blocked"}, int'(bus.tlp_blocked), 1);
      abort_req(tag, c);
    end
  endtask

  task automatic txn(input string tag, input int c, input int dcr);
    bit want;
    req_start(c, dcr);
    outcome(tag, c, dcr, want);
    if (!want) abort_req(tag, c);
  endtask

  initial begin
    bit want;
    bit seen;
    int c;
    int dcr;

    rst = 1'b1;
    bus.fc_init_done = 1'b0;
    bus.fc_upd_valid = 1'b0;
    bus.fc_upd_class = 2'd0;
    bus.fc_upd_hdr   = '0;
    bus.fc_upd_data  = '0;
    bus.tlp_valid    = 1'b0;
    bus.tlp_class    = 2'd0;
    bus.tlp_data_cr  = '0;
    repeat (3) @(negedge clk);
    check("reset.grant", int'(bus.tlp_grant), 0);
    check("reset.blocked", int'(bus.tlp_blocked), 0);
    check("reset.cc_hdr", int'(bus.cc_hdr), 0);
    rst = 1'b0;

    // Requests before the initial FC exchange must be ignored.
    bus.tlp_valid   = 1'b1;
    bus.tlp_class   = 2'd0;
    bus.tlp_data_cr = DW'(1);
    seen = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      if (bus.tlp_grant || bus.tlp_blocked) seen = 1'b1;
    end
    check("preinit.no_activity", int'(seen), 0);
    bus.tlp_valid = 1'b0;

    upd(0, 10, 100);
    upd(1, 2, 2048);
    upd(2, 50, 0);
    @(negedge clk);
    bus.fc_init_done = 1'b1;
`ifdef FC_INFINITE_CREDIT_EN
    for (int k = 0; k < 3; k++) begin
      m_inf_h[k] = (m_cl_h[k] == 0);
      m_inf_d[k] = (m_cl_d[k] == 0);
    end
`endif
    @(negedge clk);

    // Basic grant at the fastest latency.
    txn("basic", 0, 4);

    // NP exhaustion, then recovery by a header limit bump.
    txn("exh1", 1, 0);
    txn("exh2", 1, 0);
    req_start(1, 0);
    outcome("exh3", 1, 0, want);
    upd(1, 3, 2048);
    after_upd("exh_recover", 1, 0);

    // Limit update in the EVAL cycle: old limit fails, retry grants.
    upd(0, m_cc_h[0], m_cc_d[0] + 200);
    req_start(0, 1);
    bus.fc_upd_valid = 1'b1;
    bus.fc_upd_class = 2'd0;
    bus.fc_upd_hdr   = HW'(wrap(m_cc_h[0] + 5, HM));
    bus.fc_upd_data  = DW'(wrap(m_cc_d[0] + 200, DM));
    want = model_pass(0, 1);
    @(negedge clk);
    bus.fc_upd_valid = 1'b0;
    check("coll.blocked", int'(bus.tlp_blocked), int'(!want));
    model_limit(0, m_cc_h[0] + 5, m_cc_d[0] + 200);
    wait_grant("coll", 0, 1, 4);

    // Abort from WAIT leaves CC untouched.
    upd(0, m_cc_h[0], m_cc_d[0] + 200);
    req_start(0, 1);
    outcome("abort", 0, 1, want);
    abort_req("abort", 0);

    // Walk CC_h up to 254, then cross the wrap with CL_h = 2.
    for (int k = 0; k < 400 && m_cc_h[0] != 254; k++) begin
      if (!model_pass(0, 0)) upd(0, m_cc_h[0] + 100, m_cc_d[0] + 100);
      txn("walk", 0, 0);
    end
    check("walk.cc254", m_cc_h[0], 254);
    upd(0, 2, m_cc_d[0] + 100);
    for (int k = 0; k < 5; k++) txn("wrap", 0, 0);

    // Data field half-window boundary.
    upd(0, m_cc_h[0] + 10, m_cc_d[0] + 2048);
    txn("dbound_2048", 0, 2048);
    upd(0, m_cc_h[0] + 10, m_cc_d[0] + 2048);
    txn("dbound_2049", 0, 2049);

    // Completion data limit was zero at init (infinite only with the option built in).
    for (int k = 0; k < 4; k++) txn("cpl_inf", 2, 4095);

    // Randomized traffic against the ledger.
    for (int k = 0; k < 60; k++) begin
      c = $urandom_range(0, 2);
      if ($urandom_range(0, 1) == 1)
        upd(c, m_cc_h[c] + $urandom_range(0, 3), m_cc_d[c] + $urandom_range(0, DM - 1));
      dcr = $urandom_range(0, 2100);
      req_start(c, dcr);
      outcome("rnd", c, dcr, want);
      if (!want) begin
        if ($urandom_range(0, 2) == 0) begin
          abort_req("rnd", c);
        end else begin
          upd(c, m_cc_h[c] + $urandom_range(0, 4), m_cc_d[c] + dcr + $urandom_range(0, 3000));
          after_upd("rnd_upd", c, dcr);
        end
      end
    end

    // Reset during GRANT discards the pending increment.
    upd(0, m_cc_h[0] + 10, m_cc_d[0] + 100);
    req_start(0, 1);
    want = model_pass(0, 1);
    @(negedge clk);
    check("rstgrant.grant", int'(bus.tlp_grant), int'(want));
    rst = 1'b1;
    bus.tlp_valid = 1'b0;
    bus.fc_init_done = 1'b0;
    @(negedge clk);
    check("rstgrant.grant_low", int'(bus.tlp_grant), 0);
    check("rstgrant.blocked_low", int'(bus.tlp_blocked), 0);
    check("rstgrant.cc_hdr", int'(bus.cc_hdr), 0);
    rst = 1'b0;
    @(negedge clk);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
